// File: rtl/vc_domain_rr_arb3.sv
// Round-robin packet-locking arbiter for the 3-input domain-labelled mux.
// Scrubs the channel with idle cycles on every high-to-low domain handoff.
module vc_domain_rr_arb3 #(
    parameter int unsigned p_scrub = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] in_val,
    input  logic [2:0] in_last,
    input  logic [2:0] in_domain,
    input  logic       out_rdy,
    output logic [2:0] in_rdy,
    output logic       out_val,
    output logic [1:0] sel,
    output logic [2:0] grant,
    output logic       cur_domain,
    output logic       scrubbing
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK  = 2'd1,
        SCRUB = 2'd2
    } state_t;

    localparam bit         SCRUB_EN   = (p_scrub != 0);
    localparam logic [1:0] SCRUB_LOAD = SCRUB_EN ? 2'(p_scrub - 1) : 2'd0;

    state_t     state, state_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [1:0] owner, owner_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic       cur_domain_nxt;

    logic       win_vld;
    logic [1:0] win_idx;
    logic [1:0] cand;
    logic       beat_last;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    function automatic logic [2:0] onehot3(input logic [1:0] v);
        case (v)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // First valid requester starting from ptr, wrapping modulo 3.
    always_comb begin
        win_vld = 1'b0;
        win_idx = ptr;
        cand    = ptr;
        for (int k = 0; k < 3; k++) begin
            if (!win_vld && in_val[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
            cand = inc3(cand);
        end
    end

    assign beat_last = in_val[owner] && out_rdy && in_last[owner];

    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        owner_nxt      = owner;
        cnt_nxt        = cnt;
        cur_domain_nxt = cur_domain;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    if (SCRUB_EN && cur_domain && !in_domain[win_idx]) begin
                        state_nxt = SCRUB;
                        cnt_nxt   = SCRUB_LOAD;
                    end else begin
                        state_nxt      = LOCK;
                        owner_nxt      = win_idx;
                        cur_domain_nxt = in_domain[win_idx];
                    end
                end
            end
            LOCK: begin
                if (beat_last) begin
                    ptr_nxt   = inc3(owner);
                    state_nxt = IDLE;
                end
            end
            SCRUB: begin
                // Domain drops only once the last scrub cycle has elapsed.
                if (cnt == 2'd0) begin
                    cur_domain_nxt = 1'b0;
                    state_nxt      = IDLE;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= 2'd0;
            owner      <= 2'd0;
            cnt        <= 2'd0;
            cur_domain <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            owner      <= owner_nxt;
            cnt        <= cnt_nxt;
            cur_domain <= cur_domain_nxt;
        end
    end

    // Outputs depend only on registered state plus same-cycle in_val/out_rdy.
    always_comb begin
        grant   = 3'b000;
        in_rdy  = 3'b000;
        out_val = 1'b0;
        if (state == LOCK) begin
            grant   = onehot3(owner);
            in_rdy  = out_rdy ? onehot3(owner) : 3'b000;
            out_val = in_val[owner];
        end
    end

    assign sel       = owner;
    assign scrubbing = (state == SCRUB);

endmodule

// File: tb/tb_vc_domain_rr_arb3.sv
// Bench for vc_domain_rr_arb3: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_vc_domain_rr_arb3;

    localparam int P = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] in_val = 3'b000;
    logic [2:0] in_last = 3'b000;
    logic [2:0] in_domain = 3'b000;
    logic       out_rdy = 1'b1;
    logic [2:0] in_rdy;
    logic       out_val;
    logic [1:0] sel;
    logic [2:0] grant;
    logic       cur_domain;
    logic       scrubbing;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: owner index or -1, scrub cycles left, rr start.
    int m_owner;
    int m_scrub;
    int m_next;
    int m_last;
    int m_dom;

    always #5 clk = ~clk;

    vc_domain_rr_arb3 #(.p_scrub(P)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_val     (in_val),
        .in_last    (in_last),
        .in_domain  (in_domain),
        .out_rdy    (out_rdy),
        .in_rdy     (in_rdy),
        .out_val    (out_val),
        .sel        (sel),
        .grant      (grant),
        .cur_domain (cur_domain),
        .scrubbing  (scrubbing)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset     = 1'b0;
        in_val    = 3'b000;
        in_last   = 3'b000;
        in_domain = 3'b000;
        out_rdy   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        in_val    = 3'b111;
        in_last   = 3'b111;
        in_domain = 3'b000;
        out_rdy   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            n_tests++;
            if ({sel, grant, out_val, in_rdy, scrubbing, cur_domain} !== 11'b0) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: sel=%0d grant=%b out_val=%b in_rdy=%b scrub=%b dom=%b, want all 0",
                         i, sel, grant, out_val, in_rdy, scrubbing, cur_domain);
            end
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (grant !== 3'b000 || out_val !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: grant=%b out_val=%b, want 000/0", grant, out_val);
        end
        tick();
        #1;
        n_tests++;
        if (grant !== 3'b001 || sel !== 2'd0 || out_val !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_lock: grant=%b sel=%0d out_val=%b, want 001/0/1", grant, sel, out_val);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_g [8] = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
        apply_reset();
        in_val    = 3'b111;
        in_last   = 3'b111;
        in_domain = 3'b000;
        out_rdy   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_tests++;
            if (grant !== exp_g[i] || out_val !== (exp_g[i] != 3'b000) || in_rdy !== exp_g[i]) begin
                n_fail++;
                $display("FAIL rr_rotate cyc%0d: grant=%b out_val=%b in_rdy=%b, want grant/in_rdy=%b",
                         i, grant, out_val, in_rdy, exp_g[i]);
            end
            tick();
        end
    endtask

    task automatic test_packet_lock();
        apply_reset();
        in_val    = 3'b010;
        in_last   = 3'b000;
        in_domain = 3'b000;
        out_rdy   = 1'b1;
        tick();
        in_val = 3'b111;
        for (int b = 0; b < 3; b++) begin
            if (b == 2) in_last = 3'b010;
            #1;
            n_tests++;
            if (grant !== 3'b010 || sel !== 2'd1 || in_rdy !== 3'b010 || out_val !== 1'b1) begin
                n_fail++;
                $display("FAIL lock_beat%0d: grant=%b sel=%0d in_rdy=%b out_val=%b, want 010/1/010/1",
                         b, grant, sel, in_rdy, out_val);
            end
            tick();
        end
        in_last = 3'b000;
        #1;
        n_tests++;
        if (grant !== 3'b000 || sel !== 2'd1 || out_val !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_gap: grant=%b sel=%0d out_val=%b, want 000/1/0", grant, sel, out_val);
        end
        tick();
        #1;
        n_tests++;
        if (grant !== 3'b100 || sel !== 2'd2) begin
            n_fail++;
            $display("FAIL lock_next_rr: grant=%b sel=%0d, want 100/2", grant, sel);
        end
    endtask

    task automatic test_scrub();
        logic       exp_s [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       exp_d [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [2:0] exp_g [5] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010};
        apply_reset();
        in_val    = 3'b001;
        in_domain = 3'b001;
        in_last   = 3'b001;
        tick();
        #1;
        n_tests++;
        if (grant !== 3'b001 || cur_domain !== 1'b1 || out_val !== 1'b1) begin
            n_fail++;
            $display("FAIL scrub_high_beat: grant=%b dom=%b out_val=%b, want 001/1/1", grant, cur_domain, out_val);
        end
        tick();
        in_val    = 3'b010;
        in_domain = 3'b000;
        in_last   = 3'b010;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if (scrubbing !== exp_s[i] || cur_domain !== exp_d[i] || grant !== exp_g[i] ||
                out_val !== (exp_g[i] != 3'b000) || (exp_s[i] && in_rdy !== 3'b000)) begin
                n_fail++;
                $display("FAIL scrub_seq cyc%0d: scrub=%b dom=%b grant=%b out_val=%b in_rdy=%b, want %b/%b/%b",
                         i, scrubbing, cur_domain, grant, out_val, in_rdy, exp_s[i], exp_d[i], exp_g[i]);
            end
            tick();
        end
    endtask

    task automatic test_low_to_high();
        apply_reset();
        in_val    = 3'b011;
        in_domain = 3'b010;
        in_last   = 3'b011;
        tick();
        #1;
        n_tests++;
        if (grant !== 3'b001 || cur_domain !== 1'b0) begin
            n_fail++;
            $display("FAIL l2h_low: grant=%b dom=%b, want 001/0", grant, cur_domain);
        end
        tick();
        in_val = 3'b010;
        #1;
        n_tests++;
        if (grant !== 3'b000 || scrubbing !== 1'b0) begin
            n_fail++;
            $display("FAIL l2h_gap: grant=%b scrub=%b, want 000/0", grant, scrubbing);
        end
        tick();
        #1;
        n_tests++;
        if (grant !== 3'b010 || cur_domain !== 1'b1 || scrubbing !== 1'b0 || out_val !== 1'b1) begin
            n_fail++;
            $display("FAIL l2h_high: grant=%b dom=%b scrub=%b out_val=%b, want 010/1/0/1",
                     grant, cur_domain, scrubbing, out_val);
        end
    endtask

    task automatic test_stall_reset();
        apply_reset();
        in_val    = 3'b100;
        in_last   = 3'b000;
        in_domain = 3'b000;
        tick();
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if (grant !== 3'b100 || in_rdy !== 3'b000 || out_val !== 1'b1 || sel !== 2'd2) begin
                n_fail++;
                $display("FAIL stall cyc%0d: grant=%b in_rdy=%b out_val=%b sel=%0d, want 100/000/1/2",
                         i, grant, in_rdy, out_val, sel);
            end
            tick();
        end
        out_rdy = 1'b1;
        #1;
        n_tests++;
        if (in_rdy !== 3'b100) begin
            n_fail++;
            $display("FAIL stall_release: in_rdy=%b, want 100", in_rdy);
        end
        tick();
        #1;
        n_tests++;
        if (grant !== 3'b100) begin
            n_fail++;
            $display("FAIL mid_packet: grant=%b, want 100", grant);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if ({sel, grant, out_val, in_rdy, scrubbing, cur_domain} !== 11'b0) begin
            n_fail++;
            $display("FAIL async_reset: sel=%0d grant=%b out_val=%b in_rdy=%b scrub=%b dom=%b, want all 0",
                     sel, grant, out_val, in_rdy, scrubbing, cur_domain);
        end
        tick();
        reset = 1'b1;
    endtask

    task automatic model_step();
        int w;
        w = -1;
        if (m_owner >= 0) begin
            if (in_val[m_owner] && out_rdy && in_last[m_owner]) begin
                m_next  = (m_owner + 1) % 3;
                m_owner = -1;
            end
        end else if (m_scrub > 0) begin
            m_scrub--;
            if (m_scrub == 0) m_dom = 0;
        end else begin
            for (int k = 0; k < 3; k++)
                if (w < 0 && in_val[(m_next + k) % 3]) w = (m_next + k) % 3;
            if (w >= 0) begin
                if (m_dom == 1 && in_domain[w] == 1'b0 && P > 0) begin
                    m_scrub = P;
                end else begin
                    m_owner = w;
                    m_last  = w;
                    m_dom   = int'(in_domain[w]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] nval, ndom, nlast;
        logic [2:0] e_grant, e_rdy;
        logic       e_val, e_scrub, e_dom;
        logic [1:0] e_sel;
        apply_reset();
        m_owner = -1;
        m_scrub = 0;
        m_next  = 0;
        m_last  = 0;
        m_dom   = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 3; i++) begin
                nval[i]  = ($urandom_range(0, 99) < 65);
                ndom[i]  = (in_val[i] && nval[i]) ? in_domain[i] : 1'($urandom_range(0, 1));
                nlast[i] = ($urandom_range(0, 99) < 40);
            end
            in_val    = nval;
            in_domain = ndom;
            in_last   = nlast;
            out_rdy   = ($urandom_range(0, 99) < 75);
            #1;
            e_grant = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
            e_val   = (m_owner >= 0) && in_val[m_owner];
            e_rdy   = out_rdy ? e_grant : 3'b000;
            e_sel   = 2'(m_last);
            e_dom   = (m_dom != 0);
            e_scrub = (m_scrub > 0);
            n_tests++;
            if (grant !== e_grant || out_val !== e_val || in_rdy !== e_rdy || sel !== e_sel ||
                cur_domain !== e_dom || scrubbing !== e_scrub) begin
                n_fail++;
                $display("FAIL random cyc%0d: grant=%b out_val=%b in_rdy=%b sel=%0d dom=%b scrub=%b, want %b/%b/%b/%0d/%b/%b",
                         c, grant, out_val, in_rdy, sel, cur_domain, scrubbing,
                         e_grant, e_val, e_rdy, e_sel, e_dom, e_scrub);
            end
            model_step();
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_scrub();
        test_low_to_high();
        test_stall_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
